// File: rtl/bp_be_pkg.sv
// Back-end shared types and constants: writeback packet, FP register
// format and the default starvation limit used by the long writeback path.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_unicore_cfg = 2'd1
    } bp_params_e;

    localparam int unsigned dword_width_gp        = 64;
    localparam int unsigned reg_addr_width_gp     = 5;
    localparam int unsigned fp_rec_width_gp       = 65;
    localparam int unsigned fflags_width_gp       = 5;
    localparam int unsigned bp_be_starve_limit_gp = 8;

    // Recoded FP register: precision tag plus the recoded value
    typedef struct packed {
        logic                       sp_not_dp;
        logic [fp_rec_width_gp-1:0] rec;
    } bp_be_fp_reg_s;

    localparam int unsigned dpath_width_gp = $bits(bp_be_fp_reg_s);

    typedef struct packed {
        logic                         ird_w_v;
        logic                         frd_w_v;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic [dpath_width_gp-1:0]    rd_data;
        logic                         fflags_w_v;
        logic [fflags_width_gp-1:0]   fflags;
    } bp_be_wb_pkt_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with valid/ready enqueue, valid/yumi dequeue
// and an occupancy count so callers can reason about free slots.
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 2,
    localparam int unsigned ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int unsigned count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      v_i,
    output logic                      ready_o,
    output logic [width_p-1:0]        data_o,
    output logic                      v_o,
    input  logic                      yumi_i,
    output logic [count_width_lp-1:0] count_o
);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   rptr_q, rptr_d;
    logic [ptr_width_lp-1:0]   wptr_q, wptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      enq, deq;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    assign ready_o = (count_q != count_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q + count_width_lp'(enq) - count_width_lp'(deq);
        if (enq) wptr_d = ptr_inc(wptr_q);
        if (deq) rptr_d = ptr_inc(rptr_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_be_long_wb_collector.sv
// Buffers long-pipe integer/FP writebacks until the main pipe leaves the
// regfile port free, forcing it to yield once a head has waited too long.
module bp_be_long_wb_collector
    import bp_be_pkg::*;
#(
    parameter bp_params_e  bp_params_p    = e_bp_default_cfg,
    parameter int unsigned els_p          = 2,
    parameter int unsigned starve_limit_p = bp_be_starve_limit_gp,
    localparam int unsigned reg_addr_width_p = reg_addr_width_gp,
    localparam int unsigned dword_width_p    = dword_width_gp,
    localparam int unsigned wb_pkt_width_lp  = $bits(bp_be_wb_pkt_s)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    input  logic [wb_pkt_width_lp-1:0]        iwb_pkt_i,
    input  logic                              iwb_v_i,
    input  logic [wb_pkt_width_lp-1:0]        fwb_pkt_i,
    input  logic                              fwb_v_i,

    input  logic                              main_irf_w_v_i,
    input  logic                              main_frf_w_v_i,

    output logic                              irf_w_v_o,
    output logic [reg_addr_width_p-1:0]       irf_addr_o,
    output logic [dword_width_p-1:0]          irf_data_o,

    output logic                              frf_w_v_o,
    output logic [reg_addr_width_p-1:0]       frf_addr_o,
    output logic [$bits(bp_be_fp_reg_s)-1:0]  frf_data_o,

    output logic                              fflags_w_v_o,
    output logic [fflags_width_gp-1:0]        fflags_o,

    output logic                              ready_o,
    output logic                              istarve_o,
    output logic                              fstarve_o,
    output logic                              empty_o
);

    localparam int unsigned fifo_cnt_width_lp = $clog2(els_p + 1);
    localparam int unsigned wait_width_lp     = $clog2(starve_limit_p + 1);

    bp_be_wb_pkt_s iwb_pkt, fwb_pkt;
    bp_be_wb_pkt_s ihead, fhead;
    logic          ienq, fenq;
    logic          ififo_ready, ffifo_ready;
    logic [fifo_cnt_width_lp-1:0] icount, fcount;

    // Index 0 is the integer class, index 1 the FP class
    logic [1:0] head_v, pop, starve, main_w_v;

    assign iwb_pkt  = bp_be_wb_pkt_s'(iwb_pkt_i);
    assign fwb_pkt  = bp_be_wb_pkt_s'(fwb_pkt_i);
    assign main_w_v = {main_frf_w_v_i, main_irf_w_v_i};

    // Packets that would write nothing never occupy a slot
    assign ienq = iwb_v_i & ~reset_i & iwb_pkt.ird_w_v & (iwb_pkt.rd_addr != '0);
    assign fenq = fwb_v_i & ~reset_i & (fwb_pkt.frd_w_v | fwb_pkt.fflags_w_v);

    bsg_fifo_1r1w_small #(
        .width_p (wb_pkt_width_lp),
        .els_p   (els_p)
    ) u_ififo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (iwb_pkt_i),
        .v_i     (ienq),
        .ready_o (ififo_ready),
        .data_o  (ihead),
        .v_o     (head_v[0]),
        .yumi_i  (pop[0]),
        .count_o (icount)
    );

    bsg_fifo_1r1w_small #(
        .width_p (wb_pkt_width_lp),
        .els_p   (els_p)
    ) u_ffifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (fwb_pkt_i),
        .v_i     (fenq),
        .ready_o (ffifo_ready),
        .data_o  (fhead),
        .v_o     (head_v[1]),
        .yumi_i  (pop[1]),
        .count_o (fcount)
    );

    // The main pipe owns the port whenever it claims it
    assign pop = head_v & ~main_w_v & {2{~reset_i}};

    for (genvar c = 0; c < 2; c++) begin : g_wait
        logic [wait_width_lp-1:0] wait_q, wait_d;

        always_comb begin
            wait_d = '0;
            if (head_v[c] && !pop[c]) begin
                wait_d = (wait_q == wait_width_lp'(starve_limit_p))
                       ? wait_q : wait_q + wait_width_lp'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) wait_q <= '0;
            else         wait_q <= wait_d;
        end

        assign starve[c] = ~reset_i & (wait_q == wait_width_lp'(starve_limit_p));

        a_yield : assert property (@(posedge clk_i) disable iff (reset_i)
                                   !(starve[c] && main_w_v[c]))
            else $error("main pipe kept a starved writeback port, class %0d", c);
    end

    // Free-slot test includes this cycle's enqueue but not this cycle's pop
    assign ready_o = ~reset_i
                   & ((32'(icount) + 32'(ienq)) < els_p)
                   & ((32'(fcount) + 32'(fenq)) < els_p);
    assign empty_o = reset_i | ~(|head_v);

    assign irf_w_v_o  = pop[0];
    assign irf_addr_o = ihead.rd_addr;
    assign irf_data_o = ihead.rd_data[dword_width_p-1:0];

    assign frf_w_v_o    = pop[1] & fhead.frd_w_v;
    assign frf_addr_o   = fhead.rd_addr;
    assign frf_data_o   = fhead.rd_data;
    assign fflags_w_v_o = pop[1] & fhead.fflags_w_v;
    assign fflags_o     = fhead.fflags;

    assign istarve_o = starve[0];
    assign fstarve_o = starve[1];

    a_ifull : assert property (@(posedge clk_i) disable iff (reset_i) !(ienq && !ififo_ready))
        else $error("integer writeback arrived with its buffer full");
    a_ffull : assert property (@(posedge clk_i) disable iff (reset_i) !(fenq && !ffifo_ready))
        else $error("FP writeback arrived with its buffer full");
    a_cfg : assert property (@(posedge clk_i) bp_params_p == e_bp_default_cfg)
        else $error("unsupported processor configuration");

    logic unused_bits;
    assign unused_bits = ^{ihead.ird_w_v, ihead.frd_w_v, ihead.fflags_w_v, ihead.fflags,
                           ihead.rd_data[$bits(bp_be_fp_reg_s)-1:dword_width_p],
                           fhead.ird_w_v, ififo_ready, ffifo_ready};

endmodule

// File: tb/tb_bp_be_long_wb_collector.sv
// Randomized and directed bench for the long writeback collector, checked
// every cycle against a queue-based model of the buffering rules.
module tb_bp_be_long_wb_collector;
    import bp_be_pkg::*;

    localparam int ELS = 2;
    localparam int LIM = 8;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          reset_i = 1'b1;
    logic          iwb_v = 1'b0, fwb_v = 1'b0;
    bp_be_wb_pkt_s ipkt = '0, fpkt = '0;
    logic          main_i = 1'b0, main_f = 1'b0;

    logic          irf_w_v_o, frf_w_v_o, fflags_w_v_o;
    logic [4:0]    irf_addr_o, frf_addr_o, fflags_o;
    logic [63:0]   irf_data_o;
    logic [65:0]   frf_data_o;
    logic          ready_o, istarve_o, fstarve_o, empty_o;

    bp_be_long_wb_collector #(
        .bp_params_p    (e_bp_default_cfg),
        .els_p          (ELS),
        .starve_limit_p (LIM)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .iwb_pkt_i      (ipkt),
        .iwb_v_i        (iwb_v),
        .fwb_pkt_i      (fpkt),
        .fwb_v_i        (fwb_v),
        .main_irf_w_v_i (main_i),
        .main_frf_w_v_i (main_f),
        .irf_w_v_o      (irf_w_v_o),
        .irf_addr_o     (irf_addr_o),
        .irf_data_o     (irf_data_o),
        .frf_w_v_o      (frf_w_v_o),
        .frf_addr_o     (frf_addr_o),
        .frf_data_o     (frf_data_o),
        .fflags_w_v_o   (fflags_w_v_o),
        .fflags_o       (fflags_o),
        .ready_o        (ready_o),
        .istarve_o      (istarve_o),
        .fstarve_o      (fstarve_o),
        .empty_o        (empty_o)
    );

    int nchk = 0;
    int npass = 0;
    bit run = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        else npass++;
    endtask

    // Reference model: one queue per class plus a wait count per head
    bp_be_wb_pkt_s iq[$];
    bp_be_wb_pkt_s fq[$];
    int iwait = 0, fwait = 0;

    function automatic bit i_keep(input bit v, input bp_be_wb_pkt_s p);
        return v && p.ird_w_v && (p.rd_addr != 5'd0);
    endfunction

    function automatic bit f_keep(input bit v, input bp_be_wb_pkt_s p);
        return v && (p.frd_w_v || p.fflags_w_v);
    endfunction

    always @(posedge clk_i) begin
        if (reset_i) begin
            iq.delete();
            fq.delete();
            iwait = 0;
            fwait = 0;
        end else begin
            bit ip, fp;
            ip = (iq.size() > 0) && !main_i;
            fp = (fq.size() > 0) && !main_f;
            iwait = (iq.size() == 0 || ip) ? 0 : ((iwait < LIM) ? iwait + 1 : LIM);
            fwait = (fq.size() == 0 || fp) ? 0 : ((fwait < LIM) ? fwait + 1 : LIM);
            if (ip) void'(iq.pop_front());
            if (fp) void'(fq.pop_front());
            if (i_keep(iwb_v, ipkt)) iq.push_back(ipkt);
            if (f_keep(fwb_v, fpkt)) fq.push_back(fpkt);
        end
    end

    // Single compare point, mid-cycle, while inputs are stable
    always @(negedge clk_i) begin
        if (run) begin
            if (reset_i) begin
                check("rst_irf_w_v", irf_w_v_o, 0);
                check("rst_frf_w_v", frf_w_v_o, 0);
                check("rst_fflags_w_v", fflags_w_v_o, 0);
                check("rst_istarve", istarve_o, 0);
                check("rst_fstarve", fstarve_o, 0);
                check("rst_ready", ready_o, 0);
                check("rst_empty", empty_o, 1);
            end else begin
                bit ip, fp, exp_ready;
                ip = (iq.size() > 0) && !main_i;
                fp = (fq.size() > 0) && !main_f;
                exp_ready = (iq.size() + int'(i_keep(iwb_v, ipkt)) < ELS)
                         && (fq.size() + int'(f_keep(fwb_v, fpkt)) < ELS);
                check("irf_w_v", irf_w_v_o, ip);
                if (ip) begin
                    check("irf_addr", irf_addr_o, iq[0].rd_addr);
                    check("irf_data", irf_data_o, iq[0].rd_data[63:0]);
                end
                check("frf_w_v", frf_w_v_o, fp && fq[0].frd_w_v);
                check("fflags_w_v", fflags_w_v_o, fp && fq[0].fflags_w_v);
                if (fp && fq[0].frd_w_v) begin
                    check("frf_addr", frf_addr_o, fq[0].rd_addr);
                    check("frf_data", frf_data_o, fq[0].rd_data);
                end
                if (fp && fq[0].fflags_w_v) check("fflags", fflags_o, fq[0].fflags);
                check("ready", ready_o, exp_ready);
                check("empty", empty_o, (iq.size() == 0) && (fq.size() == 0));
                check("istarve", istarve_o, iwait == LIM);
                check("fstarve", fstarve_o, fwait == LIM);
            end
        end
    end

    function automatic bp_be_wb_pkt_s mk(input logic ird, input logic frd, input logic [4:0] a,
                                         input logic [65:0] d, input logic ffv, input logic [4:0] ff);
        bp_be_wb_pkt_s p;
        p.ird_w_v    = ird;
        p.frd_w_v    = frd;
        p.rd_addr    = a;
        p.rd_data    = d;
        p.fflags_w_v = ffv;
        p.fflags     = ff;
        return p;
    endfunction

    function automatic bp_be_wb_pkt_s rand_pkt();
        logic [95:0] d;
        d = {$urandom, $urandom, $urandom};
        return mk($urandom_range(9) != 0, $urandom_range(9) != 0,
                  ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)),
                  d[65:0], $urandom_range(1) == 1, 5'($urandom));
    endfunction

    // Apply one cycle of inputs just after the edge, return at mid-cycle
    task automatic cyc(input logic r, input logic iv, input bp_be_wb_pkt_s ip,
                       input logic fv, input bp_be_wb_pkt_s fp, input logic mi, input logic mf);
        @(posedge clk_i);
        #1;
        reset_i = r;
        iwb_v   = iv;
        ipkt    = ip;
        fwb_v   = fv;
        fpkt    = fp;
        main_i  = mi;
        main_f  = mf;
        @(negedge clk_i);
    endtask

    task automatic idle(input logic mi, input logic mf);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, mi, mf);
    endtask

    initial begin
        bp_be_wb_pkt_s z;
        z = '0;
        @(posedge clk_i);
        #1;
        run = 1'b1;
        cyc(1'b1, 1'b0, z, 1'b0, z, 1'b0, 1'b0);
        check("lit_rst_ready", ready_o, 0);
        check("lit_rst_empty", empty_o, 1);

        // Integer writeback appears one cycle after arrival
        cyc(1'b0, 1'b1, mk(1, 0, 5'd5, 66'h1234, 0, 0), 1'b0, z, 1'b0, 1'b0);
        check("lit_no_bypass", irf_w_v_o, 0);
        check("lit_ready_one", ready_o, 1);
        idle(0, 0);
        check("lit_i_w_v", irf_w_v_o, 1);
        check("lit_i_addr", irf_addr_o, 5);
        check("lit_i_data", irf_data_o, 64'h1234);
        idle(0, 0);
        check("lit_i_empty", empty_o, 1);

        // x0 destination is dropped
        cyc(1'b0, 1'b1, mk(1, 0, 5'd0, 66'hdead, 0, 0), 1'b0, z, 1'b0, 1'b0);
        check("lit_x0_ready", ready_o, 1);
        idle(0, 0);
        check("lit_x0_w_v", irf_w_v_o, 0);
        check("lit_x0_empty", empty_o, 1);

        // FP port held by main pipe for three cycles with two packets queued
        cyc(1'b0, 1'b0, z, 1'b1, mk(0, 1, 5'd7, 66'h2_0000_0000_0000_00AA, 1, 5'h03), 1'b0, 1'b1);
        cyc(1'b0, 1'b0, z, 1'b1, mk(0, 1, 5'd8, 66'h0_8000_0000_0000_0055, 1, 5'h10), 1'b0, 1'b1);
        check("lit_full_ready_enq", ready_o, 0);
        idle(0, 1);
        check("lit_full_ready", ready_o, 0);
        check("lit_held_w_v", frf_w_v_o, 0);
        idle(0, 0);
        check("lit_f1_w_v", frf_w_v_o, 1);
        check("lit_f1_addr", frf_addr_o, 7);
        check("lit_f1_data", frf_data_o, 66'h2_0000_0000_0000_00AA);
        check("lit_f1_fflags", fflags_o, 5'h03);
        idle(0, 0);
        check("lit_f2_addr", frf_addr_o, 8);
        check("lit_f2_fflags", fflags_o, 5'h10);
        check("lit_f2_data", frf_data_o, 66'h0_8000_0000_0000_0055);
        idle(0, 0);
        check("lit_f_empty", empty_o, 1);

        // Integer head starves behind a busy main pipe
        cyc(1'b0, 1'b1, mk(1, 0, 5'd3, 66'h77, 0, 0), 1'b0, z, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) idle(1, 0);
        check("lit_starve_before", istarve_o, 0);
        idle(0, 0);
        check("lit_starve_up", istarve_o, 1);
        check("lit_starve_pop", irf_w_v_o, 1);
        check("lit_starve_addr", irf_addr_o, 3);
        idle(0, 0);
        check("lit_starve_down", istarve_o, 0);

        // Simultaneous integer and FP writebacks, plus an fflags-only packet
        cyc(1'b0, 1'b1, mk(1, 0, 5'd9, 66'h9, 0, 0), 1'b1, mk(0, 1, 5'd10, 66'hA, 0, 0), 1'b0, 1'b0);
        idle(0, 0);
        check("lit_dual_i", irf_w_v_o, 1);
        check("lit_dual_f", frf_w_v_o, 1);
        cyc(1'b0, 1'b0, z, 1'b1, mk(0, 0, 5'd4, 66'h4, 1, 5'h1f), 1'b0, 1'b0);
        idle(0, 0);
        check("lit_ff_only_w_v", frf_w_v_o, 0);
        check("lit_ff_only_fv", fflags_w_v_o, 1);
        check("lit_ff_only_val", fflags_o, 5'h1f);

        // Reset with entries queued discards them, along with a packet in flight
        cyc(1'b0, 1'b1, mk(1, 0, 5'd11, 66'hB, 0, 0), 1'b0, z, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, mk(1, 0, 5'd12, 66'hC, 0, 0), 1'b0, z, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, z, 1'b1, mk(0, 1, 5'd13, 66'hD, 0, 0), 1'b0, 1'b0);
        check("lit_rst_no_write", irf_w_v_o, 0);
        idle(0, 0);
        check("lit_post_rst_empty", empty_o, 1);
        check("lit_post_rst_i", irf_w_v_o, 0);
        check("lit_post_rst_f", frf_w_v_o, 0);
        check("lit_post_rst_ready", ready_o, 1);

        // Random traffic with varying main-pipe pressure
        for (int n = 0; n < 3000; n++) begin
            int mprob;
            bit r, iv, fv, mi, mf;
            bp_be_wb_pkt_s ip, fp;
            @(posedge clk_i);
            #1;
            mprob = (n < 1000) ? 20 : ((n < 2000) ? 85 : 50);
            r  = ($urandom_range(199) == 0);
            mi = (iwait == LIM) ? 1'b0 : ($urandom_range(99) < mprob);
            mf = (fwait == LIM) ? 1'b0 : ($urandom_range(99) < mprob);
            ip = rand_pkt();
            fp = rand_pkt();
            iv = (iq.size() < ELS) && ($urandom_range(99) < 40);
            fv = (fq.size() < ELS) && ($urandom_range(99) < 40);
            reset_i = r;
            iwb_v   = iv;
            ipkt    = ip;
            fwb_v   = fv;
            fpkt    = fp;
            main_i  = mi;
            main_f  = mf;
        end
        for (int n = 0; n < 4; n++) idle(0, 0);
        check("lit_drain_empty", empty_o, 1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/bp_be_long_wb_collector.md
BP_BE_LONG_WB_COLLECTOR -- requirements
Module: bp_be_long_wb_collector

Interface
REQ-001 The block SHALL take parameter bp_params_p, default e_bp_default_cfg, which selects the processor configuration.
REQ-002 The block SHALL take parameter els_p, default 2, which sets the per-class buffer depth in entries.
REQ-003 The block SHALL take parameter starve_limit_p, default 8, which sets the wait cycles before the starvation request asserts.
REQ-004 Port clk_i, input, 1 bit: the only clock.
REQ-005 Port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port iwb_pkt_i, input, wb_pkt_width_lp bits: integer writeback packet from the long pipe.
REQ-007 Port iwb_v_i, input, 1 bit: one-cycle valid for iwb_pkt_i; the source cannot be backpressured.
REQ-008 Port fwb_pkt_i, input, wb_pkt_width_lp bits: FP writeback packet from the long pipe.
REQ-009 Port fwb_v_i, input, 1 bit: one-cycle valid for fwb_pkt_i; the source cannot be backpressured.
REQ-010 Port main_irf_w_v_i, input, 1 bit: the main pipe uses the integer regfile write port this cycle.
REQ-011 Port main_frf_w_v_i, input, 1 bit: the main pipe uses the FP regfile write port this cycle.
REQ-012 Ports irf_w_v_o (1), irf_addr_o (reg_addr_width_p) and irf_data_o (dword_width_p), outputs: integer regfile write.
REQ-013 Ports frf_w_v_o (1), frf_addr_o (reg_addr_width_p) and frf_data_o ($bits(bp_be_fp_reg_s)), outputs: FP regfile write.
REQ-014 Ports fflags_w_v_o (1) and fflags_o (5), outputs: accrued-exception update.
REQ-015 Port ready_o, output, 1 bit: a new long op may be dispatched.
REQ-016 Port istarve_o, output, 1 bit: the integer head is starved and the main pipe must yield the integer port.
REQ-017 Port fstarve_o, output, 1 bit: the FP head is starved and the main pipe must yield the FP port.
REQ-018 Port empty_o, output, 1 bit: both buffers are empty.

Function
REQ-019 The block SHALL enqueue iwb_pkt_i into the integer FIFO on every cycle iwb_v_i is high, and fwb_pkt_i into the FP FIFO on every cycle fwb_v_i is high.
REQ-020 The block SHALL drop, without enqueueing, an integer packet whose ird_w_v is 0 or whose rd_addr is 0.
REQ-021 The block SHALL drop, without enqueueing, an FP packet whose frd_w_v is 0 and whose fflags_w_v is 0.
REQ-022 The block SHALL assert ready_o only when both FIFOs have at least one free slot, counting any enqueue in the current cycle.
REQ-023 An enqueue while a FIFO is full SHALL be a protocol error, caught by assertion; the packet is lost.
REQ-024 The block SHALL pop the integer head, with irf_w_v_o=1 and the head's addr/data, on a cycle when the integer FIFO is non-empty and main_irf_w_v_i=0.
REQ-025 The FP path SHALL behave as REQ-024, driving frf_w_v_o from the head's frd_w_v.
REQ-026 On an FP pop, fflags_w_v_o SHALL equal the head's fflags_w_v and fflags_o SHALL equal the head's fflags.
REQ-027 Minimum latency SHALL be 1 cycle: a packet enqueued in cycle N writes the regfile no earlier than cycle N+1, and there is no same-cycle bypass.
REQ-028 An enqueue and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-029 Each class SHALL have a wait counter that increments each cycle its head is present and not popped, saturates at starve_limit_p, and clears on pop or when the FIFO is empty.
REQ-030 istarve_o or fstarve_o SHALL assert while its counter equals starve_limit_p.
REQ-031 If main_irf_w_v_i (or main_frf_w_v_i) is high while the matching starve output is asserted, that SHALL be a protocol error, caught by assertion.
REQ-032 Buffered entries are architecturally committed, so the block SHALL have no flush input and SHALL never discard buffered entries.
REQ-033 Writes SHALL retire in order within each class; no ordering SHALL be imposed between the two classes.
REQ-034 Buffering the FP data SHALL preserve the sp_not_dp bit and the recoded value unchanged.

Reset
REQ-035 While reset_i is high, both FIFOs SHALL be emptied and both counters cleared at the clock edge.
REQ-036 Reset values SHALL be: irf_w_v_o=0, frf_w_v_o=0, fflags_w_v_o=0, istarve_o=0, fstarve_o=0, ready_o=0 during reset and 1 after, and empty_o=1.
REQ-037 A packet arriving during reset SHALL be discarded.
REQ-038 Reset mid-drain SHALL abandon the remaining entries with no partial write.

Structure
REQ-039 The block SHALL use bp_be_wb_pkt_s and bp_be_fp_reg_s from bp_be_pkg and add no new typedefs.
REQ-040 The default of starve_limit_p SHALL be a localparam in bp_be_pkg, so that issue logic can share it.
REQ-041 Each class SHALL instantiate one bsg_fifo_1r1w_small of depth els_p as its natural sub-module.
REQ-042 The collector logic SHALL be shared: the block SHALL be a single module containing two instances of identical counter logic, one per class.

Verification
REQ-043 Directed test: integer pkt rd=5 with data 0x1234 and the main port idle -> irf_w_v_o=1, addr 5, data 0x1234 exactly one cycle later; empty_o returns to 1.
REQ-044 Directed test: integer pkt with rd=0 -> it is never written and ready_o stays 1.
REQ-045 Directed test: main_frf_w_v_i held high for 3 cycles with 2 FP pkts queued -> ready_o=0 while full, then writes happen in order on consecutive cycles after release, and fflags_o matches each packet.
REQ-046 Directed test: main_irf_w_v_i held high with 1 integer pkt queued -> istarve_o rises after 8 cycles; when main drops, the pop happens and istarve_o falls the next cycle.
REQ-047 Directed test: a simultaneous integer and FP pkt, both ports idle -> both regfile writes occur in the same cycle.
REQ-048 Directed test: reset asserted with 2 entries queued -> no writes occur and empty_o=1 after the reset edge.
